fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end with a small instruction
// buffer, redirect/flush handling, halt handling and an optional trap on
// misaligned redirect targets (enabled by defining FETCH_MISALIGN_TRAP_EN).
// Memory has a fixed one-cycle read latency, so at most one response is
// ever outstanding.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        halted,
   output logic        trap
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT,
      ST_TRAP
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    fetch_pc_q;
   logic           inflight_q;
   logic [31:0]    inflight_pc_q;
   logic [CW-1:0]  count_q;
   logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
   logic [31:0]    pc_mem   [FIFO_DEPTH];
   logic [31:0]    data_mem [FIFO_DEPTH];

   logic           pop;
   logic           push;
   logic           redirect_taken;
   logic           misalign;
   logic [31:0]    redirect_tgt;
   logic [CW:0]    occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign inst_valid     = (count_q != '0);
   assign inst           = data_mem[rd_ptr_q];
   assign inst_pc        = pc_mem[rd_ptr_q];
   assign imem_addr      = fetch_pc_q;
   assign halted         = (state_q == ST_HALT);
   assign pop            = inst_valid & inst_ready;
   assign redirect_taken = redirect_valid & ((state_q == ST_RUN) | (state_q == ST_HALT));
   // A response arriving in a redirect cycle belongs to the flushed stream.
   assign push           = inflight_q & ~redirect_taken;
   assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
   assign occupancy      = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign = |redirect_pc[1:0];
   assign trap     = (state_q == ST_TRAP);
`else
   logic unused_redirect_low;
   assign unused_redirect_low = ^redirect_pc[1:0];
   assign misalign = 1'b0;
   assign trap     = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and request generation.
   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN: begin
            imem_req = ~halt & ~redirect_valid & (occupancy < DEPTH_W);
            if (redirect_valid)            state_d = misalign ? ST_TRAP : ST_RUN;
            else if (halt & ~inflight_q)   state_d = ST_HALT;
         end
         ST_HALT: begin
            if (redirect_valid & misalign) state_d = ST_TRAP;
            else if (~halt)                state_d = ST_RUN;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   // Fetch PC, outstanding-response tracking and instruction buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         inflight_q <= imem_req;
         if (imem_req) begin
            fetch_pc_q    <= fetch_pc_q + 32'd4;
            inflight_pc_q <= fetch_pc_q;
         end
         if (redirect_taken) begin
            // Any simultaneous handshake is implicitly consumed by the flush.
            fetch_pc_q <= redirect_tgt;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
         end else begin
            if (push) begin
               pc_mem[wr_ptr_q]   <= inflight_pc_q;
               data_mem[wr_ptr_q] <= imem_rdata;
               wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven bench for fetch_unit with a
// one-cycle-latency ROM whose word n holds the value n.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        halted;
   logic        trap;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .halted(halted), .trap(trap)
   );

   always #5 clk = ~clk;

   // ROM: data valid one cycle after the request.
   always @(posedge clk) imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

   typedef struct {
      logic        rst;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic        exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic ready, input logic ev,
                               input logic [31:0] epc, input logic [31:0] ei,
                               input logic er, input logic [31:0] ea);
      vec_t v;
      v.rst = rst; v.ready = ready; v.exp_valid = ev; v.exp_pc = epc;
      v.exp_inst = ei; v.exp_req = er; v.exp_addr = ea;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the DUT in IDLE just after reset release, between edges.
   task automatic reset_seq(input logic ready);
      reset = 1'b1; inst_ready = ready; halt = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      tick(2);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; inst_ready = 1'b1; halt = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;

      // Startup stream, then a 10-cycle stall with a full buffer, then release.
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 32'd0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 32'd4));
      vecs.push_back(mk(0, 1, 1, 32'd0,  32'd0, 1, 32'd8));
      vecs.push_back(mk(0, 1, 1, 32'd4,  32'd1, 1, 32'd12));
      vecs.push_back(mk(0, 1, 1, 32'd8,  32'd2, 1, 32'd16));
      vecs.push_back(mk(0, 1, 1, 32'd12, 32'd3, 1, 32'd20));
      for (int k = 0; k < 10; k++) vecs.push_back(mk(0, 0, 1, 32'd16, 32'd4, 0, 0));
      vecs.push_back(mk(0, 1, 1, 32'd16, 32'd4, 1, 32'd24));
      vecs.push_back(mk(0, 1, 1, 32'd20, 32'd5, 1, 32'd28));
      vecs.push_back(mk(0, 1, 1, 32'd24, 32'd6, 1, 32'd32));

      tick(2);
      for (int i = 0; i < vecs.size(); i++) begin
         if (i > 0) tick(1);
         reset = vecs[i].rst;
         inst_ready = vecs[i].ready;
         #1;
         chk($sformatf("vec%0d.valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d.req", i), 32'(imem_req), 32'(vecs[i].exp_req));
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d.pc", i), inst_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d.inst", i), inst, vecs[i].exp_inst);
         end
         if (vecs[i].exp_req) chk($sformatf("vec%0d.addr", i), imem_addr, vecs[i].exp_addr);
         if (vecs[i].rst) begin
            chk("rst.inst", inst, 32'd0);
            chk("rst.inst_pc", inst_pc, 32'd0);
            chk("rst.halted", 32'(halted), 32'd0);
            chk("rst.trap", 32'(trap), 32'd0);
         end
      end

      // Redirect to 0x100 while the pc 8 response is in flight.
      reset_seq(1'b1);
      tick(4);
      chk("redir.head", inst_pc, 32'd4);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      #1;
      chk("redir.req_blocked", 32'(imem_req), 32'd0);
      tick(1);
      redirect_valid = 1'b0;
      #1;
      chk("redir.flushed", 32'(inst_valid), 32'd0);
      chk("redir.addr", imem_addr, 32'h100);
      chk("redir.req", 32'(imem_req), 32'd1);
      tick(1);
      chk("redir.no_stale", 32'(inst_valid), 32'd0);
      chk("redir.addr2", imem_addr, 32'h104);
      tick(1);
      chk("redir.first_pc", inst_pc, 32'h100);
      chk("redir.first_inst", inst, 32'h40);
      tick(1);
      chk("redir.second_pc", inst_pc, 32'h104);

      // Halt when fetch pc reaches 0x10, drain, then resume.
      reset_seq(1'b1);
      tick(5);
      chk("halt.addr", imem_addr, 32'h10);
      halt = 1'b1; inst_ready = 1'b0;
      #1;
      chk("halt.req0", 32'(imem_req), 32'd0);
      tick(1);
      chk("halt.pending", 32'(halted), 32'd0);
      chk("halt.req1", 32'(imem_req), 32'd0);
      tick(1);
      chk("halt.halted", 32'(halted), 32'd1);
      chk("halt.req2", 32'(imem_req), 32'd0);
      chk("halt.head0", inst_pc, 32'd8);
      inst_ready = 1'b1;
      tick(1);
      chk("halt.head1", inst_pc, 32'd12);
      chk("halt.inst1", inst, 32'd3);
      chk("halt.req3", 32'(imem_req), 32'd0);
      tick(1);
      chk("halt.drained", 32'(inst_valid), 32'd0);
      halt = 1'b0;
      #1;
      chk("halt.still", 32'(halted), 32'd1);
      chk("halt.req4", 32'(imem_req), 32'd0);
      tick(1);
      chk("halt.resumed", 32'(halted), 32'd0);
      chk("halt.resume_req", 32'(imem_req), 32'd1);
      chk("halt.resume_addr", imem_addr, 32'h10);
      tick(2);
      chk("halt.resume_pc", inst_pc, 32'h10);
      chk("halt.resume_inst", inst, 32'd4);

      // Misaligned redirect.
      reset_seq(1'b1);
      tick(3);
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      #1;
      chk("mis.req_blocked", 32'(imem_req), 32'd0);
      tick(1);
      redirect_valid = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("mis.trap%0d", k), 32'(trap), 32'd1);
         chk($sformatf("mis.valid%0d", k), 32'(inst_valid), 32'd0);
         chk($sformatf("mis.req%0d", k), 32'(imem_req), 32'd0);
         tick(1);
      end
      reset = 1'b1;
      #1;
      chk("mis.trap_cleared", 32'(trap), 32'd0);
      reset = 1'b0;
`else
      chk("mis.trap", 32'(trap), 32'd0);
      chk("mis.valid", 32'(inst_valid), 32'd0);
      chk("mis.req", 32'(imem_req), 32'd1);
      chk("mis.addr", imem_addr, 32'h100);
      tick(2);
      chk("mis.pc", inst_pc, 32'h100);
      chk("mis.inst", inst, 32'h40);
`endif

      // Asynchronous reset with two entries buffered.
      reset_seq(1'b0);
      tick(4);
      chk("ares.valid_before", 32'(inst_valid), 32'd1);
      chk("ares.req_full", 32'(imem_req), 32'd0);
      chk("ares.head", inst_pc, 32'd0);
      reset = 1'b1;
      #1;
      chk("ares.valid", 32'(inst_valid), 32'd0);
      chk("ares.req", 32'(imem_req), 32'd0);
      chk("ares.inst", inst, 32'd0);
      chk("ares.inst_pc", inst_pc, 32'd0);
      tick(1);
      reset = 1'b0; inst_ready = 1'b1;
      #1;
      chk("ares.idle_req", 32'(imem_req), 32'd0);
      tick(1);
      chk("ares.addr", imem_addr, 32'd0);
      chk("ares.req1", 32'(imem_req), 32'd1);
      tick(2);
      chk("ares.first_valid", 32'(inst_valid), 32'd1);
      chk("ares.first_pc", inst_pc, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
